// File: rtl/snake_btn_pulse.sv
`default_nettype none
// ============================================================================
// Module      : snake_btn_pulse
// Description : Synchronise and debounce four push-buttons and emit prioritised
//               one-cycle press pulses. Auto-repeat is enabled by SNAKE_BTN_REPEAT_EN.
// Revision    : 1.0
// ============================================================================
module snake_btn_pulse #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Btn_Up,
  input  logic i_Btn_Down,
  input  logic i_Btn_Left,
  input  logic i_Btn_Right,
  output logic Snake_Up,
  output logic Snake_Down,
  output logic Snake_Left,
  output logic Snake_Right,
  output logic o_Any_Press
);

  localparam int c_DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_DBW-1:0] c_DB_MAX = c_DBW'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the highest-priority button.
  logic [3:0] w_btn_raw;
  logic [3:0] w_evt;
  logic [3:0] w_grant;

  assign w_btn_raw = {i_Btn_Right, i_Btn_Left, i_Btn_Down, i_Btn_Up};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_btn
      logic             r_sync1;
      logic             r_sync2;
      logic             r_stable;
      logic             r_stable_d;
      logic [c_DBW-1:0] r_db_cnt;
      logic             w_evt_init;

      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_db_cnt   <= '0;
        end else begin
          r_sync1    <= w_btn_raw[g];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == c_DB_MAX) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
      end

      // Only the rising edge of the accepted level is a press.
      assign w_evt_init = r_stable & ~r_stable_d;

`ifdef SNAKE_BTN_REPEAT_EN
      localparam int c_RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      localparam logic [c_RPW-1:0] c_RP_MAX = c_RPW'(REPEAT_CYCLES - 1);

      logic [c_RPW-1:0] r_rep_cnt;
      logic             w_evt_rep;

      assign w_evt_rep = r_stable & r_stable_d & (r_rep_cnt == c_RP_MAX);

      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          r_rep_cnt <= '0;
        end else if (!r_stable || w_evt_init || w_evt_rep) begin
          r_rep_cnt <= '0;
        end else begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end

      assign w_evt[g] = w_evt_init | w_evt_rep;
`else
      assign w_evt[g] = w_evt_init;
`endif
    end
  endgenerate

  // Fixed priority; losing events are simply dropped.
  always_comb begin
    w_grant = 4'b0000;
    if (w_evt[0])      w_grant = 4'b0001;
    else if (w_evt[1]) w_grant = 4'b0010;
    else if (w_evt[2]) w_grant = 4'b0100;
    else if (w_evt[3]) w_grant = 4'b1000;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      Snake_Up    <= 1'b0;
      Snake_Down  <= 1'b0;
      Snake_Left  <= 1'b0;
      Snake_Right <= 1'b0;
      o_Any_Press <= 1'b0;
    end else begin
      Snake_Up    <= w_grant[0];
      Snake_Down  <= w_grant[1];
      Snake_Left  <= w_grant[2];
      Snake_Right <= w_grant[3];
      o_Any_Press <= |w_grant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_btn_pulse.sv
`default_nettype none
// Bench for snake_btn_pulse: directed table, hand-written corner sequences and
// randomized stimulus against a window-based reference model.
module tb_snake_btn_pulse;
  localparam int D = 4;
  localparam int R = 16;
`ifdef SNAKE_BTN_REPEAT_EN
  localparam int RPT60 = 4;
  localparam int UP2   = 2;
`else
  localparam int RPT60 = 1;
  localparam int UP2   = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'b0000;   // [0]=Up [1]=Down [2]=Left [3]=Right
  logic       s_up, s_dn, s_lf, s_rt, any_p;
  logic [4:0] dut_o;
  int         n_vec = 0;
  int         n_err = 0;

  assign dut_o = {s_up, s_dn, s_lf, s_rt, any_p};

  always #5 clk = ~clk;

  snake_btn_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Btn_Up(btn[0]), .i_Btn_Down(btn[1]), .i_Btn_Left(btn[2]), .i_Btn_Right(btn[3]),
    .Snake_Up(s_up), .Snake_Down(s_dn), .Snake_Left(s_lf), .Snake_Right(s_rt),
    .o_Any_Press(any_p)
  );

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_cnt(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a stable level flips once the last D synchronised
  // samples (raw samples delayed by two clocks) all disagree with it.
  bit         hist [4][$];
  bit         m_stable [4];
  int         m_age [4];
  logic [3:0] m_evt;
  logic [4:0] exp_o;
  bit         m_flip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        hist[b].delete();
        for (int i = 0; i < D + 2; i++) hist[b].push_back(1'b0);
        m_stable[b] = 1'b0;
        m_age[b]    = 0;
      end
      exp_o = 5'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
`ifdef SNAKE_BTN_REPEAT_EN
        m_evt[b] = m_stable[b] && (m_age[b] % R == 0);
`else
        m_evt[b] = m_stable[b] && (m_age[b] == 0);
`endif
      end
      exp_o[4] = m_evt[0];
      exp_o[3] = m_evt[1] && !m_evt[0];
      exp_o[2] = m_evt[2] && (m_evt[1:0] == 2'b00);
      exp_o[1] = m_evt[3] && (m_evt[2:0] == 3'b000);
      exp_o[0] = |m_evt;
      for (int b = 0; b < 4; b++) begin
        hist[b].push_back(btn[b]);
        void'(hist[b].pop_front());
        m_flip = 1'b1;
        for (int i = 0; i < D; i++) if (hist[b][i] == m_stable[b]) m_flip = 1'b0;
        if (m_flip) begin
          m_stable[b] = !m_stable[b];
          m_age[b]    = 0;
        end else if (m_stable[b]) begin
          m_age[b]++;
        end
      end
    end
  end

  always @(negedge clk) check("model", dut_o, exp_o);

  typedef struct {
    logic [3:0] b;
    int         hold;
    int         e_up, e_dn, e_lf, e_rt;
  } vec_t;

  vec_t tbl [7];
  int   c_up, c_dn, c_lf, c_rt;

  task automatic idle(input int n);
    btn = 4'b0000;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{4'b0001, 14, 1, 0, 0, 0};
    tbl[1] = '{4'b1010, 14, 0, 1, 0, 0};
    tbl[2] = '{4'b1111, 14, 1, 0, 0, 0};
    tbl[3] = '{4'b1100, 14, 0, 0, 1, 0};
    tbl[4] = '{4'b1000, 60, 0, 0, 0, RPT60};
    tbl[5] = '{4'b0100,  3, 0, 0, 0, 0};
    tbl[6] = '{4'b0110, 14, 0, 1, 0, 0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", dut_o, 5'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Up latency: pulse only after the 7th edge of the hold.
    btn[0] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check("up_latency", dut_o, (e == 7) ? 5'b10001 : 5'b00000);
    end
    idle(14);

    for (int i = 0; i < 7; i++) begin
      btn = tbl[i].b;
      c_up = 0; c_dn = 0; c_lf = 0; c_rt = 0;
      for (int c = 0; c < tbl[i].hold + 14; c++) begin
        @(negedge clk);
        c_up += int'(s_up); c_dn += int'(s_dn); c_lf += int'(s_lf); c_rt += int'(s_rt);
        if (c == tbl[i].hold - 1) btn = 4'b0000;
      end
      check_cnt($sformatf("tbl%0d_up", i), c_up, tbl[i].e_up);
      check_cnt($sformatf("tbl%0d_down", i), c_dn, tbl[i].e_dn);
      check_cnt($sformatf("tbl%0d_left", i), c_lf, tbl[i].e_lf);
      check_cnt($sformatf("tbl%0d_right", i), c_rt, tbl[i].e_rt);
    end

    // Left glitches of 3 clocks never reach the outputs.
    c_lf = 0;
    for (int r = 0; r < 5; r++) begin
      btn[2] = 1'b1;
      repeat (3) begin @(negedge clk); c_lf += int'(any_p); end
      btn[2] = 1'b0;
      repeat (3) begin @(negedge clk); c_lf += int'(any_p); end
    end
    repeat (8) begin @(negedge clk); c_lf += int'(any_p); end
    check_cnt("glitch_any", c_lf, 0);

    // Holding Up does not block a later Left press.
    c_up = 0;
    btn[0] = 1'b1;
    repeat (20) begin @(negedge clk); c_up += int'(s_up); end
    btn[2] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      c_up += int'(s_up);
      if (e <= 9) check_cnt("left_while_up", int'(s_lf), (e == 7) ? 1 : 0);
    end
    check_cnt("up_while_left", c_up, UP2);
    idle(14);

    // Reset mid-debounce discards the count; held button re-presses.
    btn[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_debounce", dut_o, 5'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check("up_after_release", dut_o, (e == 7) ? 5'b10001 : 5'b00000);
    end
    idle(14);

    // Reset during a live pulse clears outputs immediately.
    btn[1] = 1'b1;
    repeat (7) @(negedge clk);
    check("down_pulse", dut_o, 5'b01001);
    #2 rst_n = 1'b0;
    #1 check("reset_async", dut_o, 5'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check("down_after_release", dut_o, (e == 7) ? 5'b01001 : 5'b00000);
    end
    idle(14);

    // Random toggling with occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) btn[b] = ~btn[b];
      if ($urandom_range(599) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
